// File: rtl/minmax_scan.sv
// minmax_scan: scans a burst of signed words and reports the minimum and
// maximum plus the index of the first occurrence of each. One shared
// lessOrEqual comparator is time-multiplexed between the min and max checks.
// Optional feature macro: MINMAX_SCAN_ABORT_EN adds an abort input and a
// one-cycle aborted pulse.

// Shared comparator: eq is high when a <= b (signed two's complement).
module less_or_equal #(
   parameter int WIDTH = 32
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic                    eq
);
   assign eq = (a <= b);
endmodule

module minmax_scan #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [CNT_W-1:0]        len,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_data,
`ifdef MINMAX_SCAN_ABORT_EN
   input  logic                    abort,
   output logic                    aborted,
`endif
   output logic                    in_ready,
   output logic                    busy,
   output logic                    done,
   output logic                    empty,
   output logic signed [WIDTH-1:0] min_out,
   output logic signed [WIDTH-1:0] max_out,
   output logic [CNT_W-1:0]        min_idx,
   output logic [CNT_W-1:0]        max_idx
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CMP_MIN = 3'd2,
      CMP_MAX = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t                  state, nxt;
   logic [CNT_W-1:0]        len_q;
   logic [CNT_W-1:0]        idx;
   logic signed [WIDTH-1:0] x;

   // control strobes decoded from the current state
   logic cap, xfer, first, upd_min, upd_max, inc;
   logic last;

   // comparator operands and result
   logic signed [WIDTH-1:0] cmp_a, cmp_b;
   logic                    eq;

   assign last = (idx == len_q - CNT_W'(1));

   // CMP_MAX asks "x <= max"; every other state asks "min <= x"
   assign cmp_a = (state == CMP_MAX) ? x       : min_out;
   assign cmp_b = (state == CMP_MAX) ? max_out : x;

   less_or_equal #(.WIDTH(WIDTH)) u_le (
      .a  (cmp_a),
      .b  (cmp_b),
      .eq (eq)
   );

`ifdef MINMAX_SCAN_ABORT_EN
   logic abort_now;
   assign abort_now = abort && (state != IDLE);
   assign in_ready  = (state == FETCH) && !abort;
   assign done      = (state == DONE) && !abort;
`else
   assign in_ready  = (state == FETCH);
   assign done      = (state == DONE);
`endif
   assign busy = (state != IDLE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // next-state and datapath strobes
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      nxt     = state;
      cap     = 1'b0;
      xfer    = 1'b0;
      first   = 1'b0;
      upd_min = 1'b0;
      upd_max = 1'b0;
      inc     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               cap = 1'b1;
               nxt = (len == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (in_valid) begin
               xfer = 1'b1;
               if (idx == '0) begin
                  first = 1'b1;
                  if (len_q == CNT_W'(1)) nxt = DONE;
                  else                    inc = 1'b1;
               end else begin
                  nxt = CMP_MIN;
               end
            end
         end
         CMP_MIN: begin
            upd_min = !eq;               // min > x, strict so ties keep the older index
            nxt     = CMP_MAX;
         end
         CMP_MAX: begin
            upd_max = !eq;               // x > max
            if (last) nxt = DONE;
            else begin
               inc = 1'b1;
               nxt = FETCH;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
`ifdef MINMAX_SCAN_ABORT_EN
      // abort overrides every transition and suppresses all updates
      if (abort_now) begin
         nxt     = IDLE;
         xfer    = 1'b0;
         first   = 1'b0;
         upd_min = 1'b0;
         upd_max = 1'b0;
         inc     = 1'b0;
      end
`endif
   end

   // datapath registers: length, index, element, results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all
         // registers update from the same pre-edge values.
         len_q   <= '0;
         idx     <= '0;
         x       <= '0;
         empty   <= 1'b0;
         min_out <= '0;
         max_out <= '0;
         min_idx <= '0;
         max_idx <= '0;
      end else begin
         if (cap) begin
            len_q <= len;
            idx   <= '0;
            empty <= (len == '0);
         end
         if (xfer) x <= in_data;
         if (first) begin
            min_out <= in_data;
            max_out <= in_data;
            min_idx <= '0;
            max_idx <= '0;
         end
         if (upd_min) begin
            min_out <= x;
            min_idx <= idx;
         end
         if (upd_max) begin
            max_out <= x;
            max_idx <= idx;
         end
         if (inc) idx <= idx + CNT_W'(1);
      end
   end

`ifdef MINMAX_SCAN_ABORT_EN
   // one-cycle pulse marking an abandoned scan
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) aborted <= 1'b0;
      else        aborted <= abort_now;
   end
`endif

endmodule

// File: tb/tb_minmax_scan.sv
// tb_minmax_scan: directed plus randomized scans of minmax_scan, compared
// against a plain array-based min/max reference model.

module tb_minmax_scan;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [7:0]         len = '0;
   logic               in_valid = 1'b0;
   logic signed [31:0] in_data = '0;
   logic               in_ready, busy, done, empty;
   logic signed [31:0] min_out, max_out;
   logic [7:0]         min_idx, max_idx;

   int total = 0;
   int bad   = 0;

   int stim [0:255];

   // reference model state (persists across scans so len==0 keeps results)
   int exp_min = 0, exp_max = 0, exp_mi = 0, exp_xi = 0, exp_empty = 0;

   minmax_scan #(.WIDTH(32), .CNT_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .len      (len),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .empty    (empty),
      .min_out  (min_out),
      .max_out  (max_out),
      .min_idx  (min_idx),
      .max_idx  (max_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // reference: first-occurrence min/max over stim[0..n-1]
   task automatic model(input int n);
      if (n == 0) begin
         exp_empty = 1;
      end else begin
         exp_empty = 0;
         exp_min = stim[0]; exp_max = stim[0]; exp_mi = 0; exp_xi = 0;
         for (int i = 1; i < n; i++) begin
            if (stim[i] < exp_min) begin exp_min = stim[i]; exp_mi = i; end
            if (stim[i] > exp_max) begin exp_max = stim[i]; exp_xi = i; end
         end
      end
   endtask

   task automatic check_results(input string tag);
      check({tag, ".min"},   min_out, exp_min);
      check({tag, ".max"},   max_out, exp_max);
      check({tag, ".mi"},    {24'b0, min_idx}, exp_mi);
      check({tag, ".xi"},    {24'b0, max_idx}, exp_xi);
      check({tag, ".empty"}, {31'b0, empty}, exp_empty);
   endtask

   // run one scan of stim[0..n-1]; in_valid drops for gap cycles after each transfer
   task automatic do_scan(input string tag, input int n, input int gap);
      int sent, gapc, cyc, dcnt, rdy, lat;
      sent = 0; gapc = 0; cyc = 0; dcnt = 0; rdy = 0; lat = -1;
      @(posedge clk) #1;
      start = 1'b1; len = 8'(n);
      @(posedge clk) #1;
      start = 1'b0; cyc = 1;
      while (dcnt == 0 && cyc < 2000) begin
         if (gapc > 0) begin
            in_valid = 1'b0; gapc--;
         end else begin
            in_valid = (sent < n);
            if (sent < n) in_data = stim[sent];
         end
         @(negedge clk);
         if (in_ready) rdy++;
         if (in_valid && in_ready) begin sent++; gapc = gap; end
         if (done) begin dcnt++; lat = cyc; end
         @(posedge clk) #1;
         cyc++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      if (done) dcnt++;
      model(n);
      check({tag, ".done_once"}, dcnt, 1);
      check({tag, ".consumed"}, sent, n);
      if (n == 0) check({tag, ".no_ready"}, rdy, 0);
      if (gap == 0) check({tag, ".latency"}, lat, (n == 0) ? 1 : 3 * n - 1);
      check({tag, ".idle"}, {31'b0, busy}, 0);
      check_results(tag);
   endtask

   initial begin
      int sent, gapc, guard, dcnt;

      // reset state
      #12;
      check("rst.busy", {31'b0, busy}, 0);
      check("rst.done", {31'b0, done}, 0);
      check("rst.ready", {31'b0, in_ready}, 0);
      check("rst.empty", {31'b0, empty}, 0);
      check("rst.min", min_out, 0);
      check("rst.max", max_out, 0);
      check("rst.mi", {24'b0, min_idx}, 0);
      check("rst.xi", {24'b0, max_idx}, 0);
      #3 rst_n = 1'b1;

      // directed cases
      stim[0] = 1; stim[1] = 2; stim[2] = -2; stim[3] = -1; stim[4] = 0;
      do_scan("len5", 5, 0);
      stim[0] = 5; stim[1] = -1; stim[2] = 5; stim[3] = -1;
      do_scan("ties", 4, 0);
      stim[0] = 32'h7FFF_FFFF; stim[1] = 32'h8000_0000;
      do_scan("extremes", 2, 0);
      stim[0] = -7;
      do_scan("len1", 1, 0);
      do_scan("len0", 0, 0);
      check("len0.min_kept", min_out, -7);

      // randomized scans, some with tie-heavy small ranges and gapped valid
      for (int k = 0; k < 8; k++) begin
         int n;
         n = $urandom_range(20, 1);
         for (int i = 0; i < n; i++)
            stim[i] = (k % 2 == 0) ? int'($urandom) : int'($urandom_range(6)) - 3;
         do_scan($sformatf("rnd%0d", k), n, $urandom_range(2));
      end

      // gapped scan interrupted by reset during CMP_MIN of element 1
      stim[0] = 4; stim[1] = -9; stim[2] = 6;
      @(posedge clk) #1;
      start = 1'b1; len = 8'd3;
      @(posedge clk) #1;
      start = 1'b0;
      sent = 0; gapc = 0; guard = 0;
      while (sent < 2 && guard < 200) begin
         if (gapc > 0) begin
            in_valid = 1'b0; gapc--;
         end else begin
            in_valid = 1'b1; in_data = stim[sent];
         end
         @(negedge clk);
         if (in_valid && in_ready) begin sent++; gapc = 2; end
         guard++;
         if (sent < 2) @(posedge clk) #1;
      end
      check("abrt.reached", sent, 2);
      @(posedge clk) #1;
      in_valid = 1'b0;
      check("abrt.busy_before", {31'b0, busy}, 1);
      check("abrt.ready_before", {31'b0, in_ready}, 0);
      rst_n = 1'b0;
      #1;
      check("abrt.busy", {31'b0, busy}, 0);
      check("abrt.done", {31'b0, done}, 0);
      check("abrt.min", min_out, 0);
      check("abrt.max", max_out, 0);
      check("abrt.mi", {24'b0, min_idx}, 0);
      check("abrt.xi", {24'b0, max_idx}, 0);
      #10 rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("abrt.no_done", dcnt, 0);

      stim[0] = 0; stim[1] = 0; stim[2] = 0;
      do_scan("zeros", 3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
